// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter and
// mode-gated rise/fall pulse generation, plus sticky flags and a shared irq.

// One channel: sync chain, debounce counter, filtered level and pulse regs.
module edge_detector_ch #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CYCLES  = 1,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sig_in,
    input  logic [1:0] mode,
    output logic       level_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       rise_nxt,
    output logic       fall_nxt
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   sync_out;
    logic                   differ;
    logic                   accept;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign differ   = (sync_out != level_out);
    // A new level is accepted on the DEB_CYCLES-th consecutive differing sample.
    assign accept   = differ && (cnt == CW'(DEB_CYCLES - 1));
    // Mode is sampled at the accepting edge only; level tracking ignores it.
    assign rise_nxt = accept &  sync_out & mode[0];
    assign fall_nxt = accept & ~sync_out & mode[1];

    // Synchroniser chain; sig_in is never used past the first stage.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        else            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end

    // Debounce counter and filtered level; any return to the old level restarts the count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt       <= '0;
            level_out <= INIT_LEVEL;
        end else if (!differ) begin
            cnt <= '0;
        end else if (accept) begin
            cnt       <= '0;
            level_out <= sync_out;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered single-cycle pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end
endmodule

module edge_detector_multi #(
    parameter int   CH          = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CYCLES  = 1,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic [CH-1:0]   sig_in,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   flag_clr,
    output logic [CH-1:0]   level_out,
    output logic [CH-1:0]   rise_pulse,
    output logic [CH-1:0]   fall_pulse,
    output logic [CH-1:0]   edge_pulse,
    output logic [CH-1:0]   edge_flag,
    output logic            irq
);
    logic [CH-1:0] rise_nxt;
    logic [CH-1:0] fall_nxt;
    logic [CH-1:0] edge_flag_nxt;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        edge_detector_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES),
            .INIT_LEVEL (INIT_LEVEL)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .sig_in    (sig_in[g]),
            .mode      (mode[2*g +: 2]),
            .level_out (level_out[g]),
            .rise_pulse(rise_pulse[g]),
            .fall_pulse(fall_pulse[g]),
            .rise_nxt  (rise_nxt[g]),
            .fall_nxt  (fall_nxt[g])
        );
    end

    // Both pulse sources are registers, so the OR is glitch-free and aligned.
    assign edge_pulse = rise_pulse | fall_pulse;

    // Sticky flag next state: a new edge wins over a same-cycle clear.
    always_comb begin
        edge_flag_nxt = (rise_nxt | fall_nxt) | (edge_flag & ~flag_clr);
    end

    // Flags and irq; irq follows next-state flags so it rises with the flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            edge_flag <= '0;
            irq       <= 1'b0;
        end else begin
            edge_flag <= edge_flag_nxt;
            irq       <= |edge_flag_nxt;
        end
    end
endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: a default instance (8 ch, no filtering) and a
// 2-channel instance with DEB_CYCLES=4, checked against a history-based model.
module tb_edge_detector_multi;
    localparam int SYNC = 2;
    localparam int DEB_A = 1;
    localparam int DEB_B = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  sig_a = '0, clr_a = '0;
    logic [15:0] mode_a = '0;
    logic [1:0]  sig_b = '0, clr_b = '0;
    logic [3:0]  mode_b = '0;
    logic [7:0]  level_a, rise_a, fall_a, edge_a, flag_a;
    logic [1:0]  level_b, rise_b, fall_b, edge_b, flag_b;
    logic        irq_a, irq_b;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    edge_detector_multi dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sig_in(sig_a), .mode(mode_a),
        .flag_clr(clr_a), .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
        .edge_pulse(edge_a), .edge_flag(flag_a), .irq(irq_a)
    );

    edge_detector_multi #(.CH(2), .DEB_CYCLES(DEB_B)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sig_in(sig_b), .mode(mode_b),
        .flag_clr(clr_b), .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
        .edge_pulse(edge_b), .edge_flag(flag_b), .irq(irq_b)
    );

    // Reference model: inputs recorded per clock edge; the synchronised value
    // seen at edge e is the raw input recorded at edge e-SYNC. A level is
    // accepted once the synchronised value has differed for DEB samples in a row.
    logic [7:0] hist0[$];
    logic [7:0] hist1[$];
    int m_run [2][8];
    bit m_lvl [2][8];
    bit m_rise[2][8];
    bit m_fall[2][8];
    bit m_flag[2][8];
    bit m_irq [2];

    task automatic model_reset();
        hist0.delete();
        hist1.delete();
        for (int u = 0; u < 2; u++) begin
            m_irq[u] = 0;
            for (int i = 0; i < 8; i++) begin
                m_run[u][i] = 0; m_lvl[u][i] = 0; m_rise[u][i] = 0;
                m_fall[u][i] = 0; m_flag[u][i] = 0;
            end
        end
    endtask

    task automatic model_ch(input int u, input int i, input int deb, input bit s,
                            input bit en_r, input bit en_f, input bit clr);
        m_rise[u][i] = 0;
        m_fall[u][i] = 0;
        if (s != m_lvl[u][i]) m_run[u][i]++;
        else                  m_run[u][i] = 0;
        if (m_run[u][i] == deb) begin
            m_lvl[u][i] = s;
            m_run[u][i] = 0;
            if (s) m_rise[u][i] = en_r;
            else   m_fall[u][i] = en_f;
        end
        m_flag[u][i] = m_rise[u][i] | m_fall[u][i] | (m_flag[u][i] & !clr);
    endtask

    task automatic model_step();
        logic [7:0] h;
        bit s;
        hist0.push_back(sig_a);
        hist1.push_back({6'b0, sig_b});
        for (int i = 0; i < 8; i++) begin
            s = 1'b0;
            if (hist0.size() > SYNC) begin h = hist0[hist0.size()-1-SYNC]; s = h[i]; end
            model_ch(0, i, DEB_A, s, mode_a[2*i], mode_a[2*i+1], clr_a[i]);
        end
        for (int i = 0; i < 2; i++) begin
            s = 1'b0;
            if (hist1.size() > SYNC) begin h = hist1[hist1.size()-1-SYNC]; s = h[i]; end
            model_ch(1, i, DEB_B, s, mode_b[2*i], mode_b[2*i+1], clr_b[i]);
        end
        for (int u = 0; u < 2; u++) begin
            m_irq[u] = 0;
            for (int i = 0; i < 8; i++) m_irq[u] |= m_flag[u][i];
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [7:0] el, er, ef, fl;
        for (int u = 0; u < 2; u++) begin
            el = '0; er = '0; ef = '0; fl = '0;
            for (int i = 0; i < 8; i++) begin
                el[i] = m_lvl[u][i]; er[i] = m_rise[u][i];
                ef[i] = m_fall[u][i]; fl[i] = m_flag[u][i];
            end
            if (u == 0) begin
                chk("model level_a", level_a, el);
                chk("model rise_a", rise_a, er);
                chk("model fall_a", fall_a, ef);
                chk("model edge_a", edge_a, er | ef);
                chk("model flag_a", flag_a, fl);
                chk("model irq_a", 8'(irq_a), 8'(m_irq[0]));
            end else begin
                chk("model level_b", 8'(level_b), el);
                chk("model rise_b", 8'(rise_b), er);
                chk("model fall_b", 8'(fall_b), ef);
                chk("model edge_b", 8'(edge_b), er | ef);
                chk("model flag_b", 8'(flag_b), fl);
                chk("model irq_b", 8'(irq_b), 8'(m_irq[1]));
            end
        end
    endtask

    // One clock: model advances on the edge, outputs compared at the negedge.
    task automatic step();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst level_a", level_a, 8'h00);
        chk("rst edge_a", edge_a | rise_a | fall_a, 8'h00);
        chk("rst flag_a", flag_a, 8'h00);
        chk("rst irq", 8'({irq_a, irq_b}), 8'h00);
        chk("rst b outs", 8'({level_b, rise_b, fall_b, flag_b}), 8'h00);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  sig;
        logic [15:0] md;
        logic [7:0]  clr;
        logic [7:0]  lvl;
        logic [7:0]  rise;
        logic [7:0]  fall;
        logic [7:0]  flag;
        logic        irq;
    } vec_t;

    vec_t tbl[9];
    int n_rise, n_fall, n_edge;

    initial begin
        // ch0 rise-only: rise pulses at edge 2, falling edge gives no pulse.
        tbl[0] = '{8'h01, 16'h0001, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{8'h01, 16'h0001, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{8'h01, 16'h0001, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1};
        tbl[3] = '{8'h01, 16'h0001, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[4] = '{8'h00, 16'h0001, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[5] = '{8'h00, 16'h0001, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[6] = '{8'h00, 16'h0001, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[7] = '{8'h00, 16'h0001, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[8] = '{8'h00, 16'h0001, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

        do_reset();

        for (int k = 0; k < 9; k++) begin
            sig_a = tbl[k].sig; mode_a = tbl[k].md; clr_a = tbl[k].clr;
            step();
            chk($sformatf("tbl%0d level", k), level_a, tbl[k].lvl);
            chk($sformatf("tbl%0d rise", k), rise_a, tbl[k].rise);
            chk($sformatf("tbl%0d fall", k), fall_a, tbl[k].fall);
            chk($sformatf("tbl%0d edge", k), edge_a, tbl[k].rise | tbl[k].fall);
            chk($sformatf("tbl%0d flag", k), flag_a, tbl[k].flag);
            chk($sformatf("tbl%0d irq", k), 8'(irq_a), 8'(tbl[k].irq));
        end
        clr_a = '0;

        // ch3 in both-edge mode: one rise, one fall, flag sticky until cleared.
        mode_a = 16'h00C0;
        n_rise = 0; n_fall = 0; n_edge = 0;
        sig_a[3] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) sig_a[3] = 1'b0;
            step();
            n_rise += int'(rise_a[3]); n_fall += int'(fall_a[3]); n_edge += int'(edge_a[3]);
        end
        chk("ch3 rise count", 8'(n_rise), 8'd1);
        chk("ch3 fall count", 8'(n_fall), 8'd1);
        chk("ch3 edge count", 8'(n_edge), 8'd2);
        chk("ch3 flag held", 8'(flag_a[3]), 8'd1);
        clr_a[3] = 1'b1;
        step();
        clr_a[3] = 1'b0;
        chk("ch3 flag cleared", 8'(flag_a[3]), 8'd0);
        chk("ch3 irq cleared", 8'(irq_a), 8'd0);

        // ch1: clear held high across the accepting edge; set wins once.
        mode_a = 16'h0004;
        clr_a[1] = 1'b1;
        sig_a[1] = 1'b1;
        step(); step(); step();
        chk("setwins rise1", 8'(rise_a[1]), 8'd1);
        chk("setwins flag1", 8'(flag_a[1]), 8'd1);
        chk("setwins irq", 8'(irq_a), 8'd1);
        step();
        chk("setwins flag1 after", 8'(flag_a[1]), 8'd0);
        clr_a[1] = 1'b0;
        sig_a[1] = 1'b0;
        repeat (4) step();

        // ch2: edge while mode off is tracked silently; enabling mode adds no pulse.
        mode_a = 16'h0000;
        sig_a[2] = 1'b1;
        repeat (5) step();
        chk("off level2", 8'(level_a[2]), 8'd1);
        chk("off flag2", 8'(flag_a[2]), 8'd0);
        mode_a = 16'h0010;
        repeat (3) step();
        chk("mode switch no pulse", edge_a, 8'h00);
        sig_a[2] = 1'b0;
        repeat (5) step();
        chk("ch2 fall masked", 8'(flag_a[2]), 8'd0);
        sig_a[2] = 1'b1;
        step(); step(); step();
        chk("ch2 next rise", 8'(rise_a[2]), 8'd1);

        // DEB=4: a 3-cycle glitch is filtered, a 4-cycle high is accepted at k=5.
        mode_b = 4'b0001;
        sig_b = 2'b01;
        for (int k = 0; k < 11; k++) begin
            if (k == 3) sig_b = 2'b00;
            step();
            chk("glitch no rise", 8'(rise_b), 8'd0);
            chk("glitch level", 8'(level_b), 8'd0);
        end
        sig_b = 2'b01;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) sig_b = 2'b00;
            step();
            chk($sformatf("deb4 rise k%0d", k), 8'(rise_b[0]), 8'((k == 5) ? 1 : 0));
        end
        repeat (4) step();

        // Reset mid-debounce with sig_b high; full latency after release.
        sig_a = '0;
        sig_b = 2'b01;
        step(); step(); step();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("post-rst rise_b k%0d", k), 8'(rise_b[0]), 8'((k == 5) ? 1 : 0));
            chk("post-rst quiet a", edge_a, 8'h00);
        end

        // Randomised traffic on both instances against the model.
        for (int k = 0; k < 600; k++) begin
            sig_a = sig_a ^ 8'($urandom & $urandom);
            sig_b = sig_b ^ 2'($urandom & $urandom & $urandom);
            clr_a = 8'($urandom & $urandom & $urandom);
            clr_b = 2'($urandom & $urandom);
            if (k % 16 == 0) begin
                mode_a = 16'($urandom);
                mode_b = 4'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
- Multi-channel edge detector: synchronises CH asynchronous inputs, applies an optional per-design debounce filter, and emits single-cycle rise/fall/any-edge pulses per channel.
- Each channel has a mode select (off, rise, fall, both), a sticky edge flag with software clear, and a shared interrupt output.
- Sits between raw board I/O (buttons, external strobes) and control FSMs or a register interface.

Parameters:
CH, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
DEB_CYCLES, 1, consecutive cycles a new level must persist before acceptance (>=1; 1 = no filtering)
INIT_LEVEL, 1'b0, reset value of synchroniser stages and filtered level (all channels)

Ports:
sys_clk  input  1  clock
sys_rst_n  input  1  asynchronous active-low reset
sig_in  input  CH  raw asynchronous inputs, bit i = channel i
mode  input  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
flag_clr  input  CH  per-channel sticky flag clear, level-sensitive, sampled each cycle
level_out  output  CH  filtered, synchronised level
rise_pulse  output  CH  1-cycle pulse on accepted 0->1 (gated by mode[2i])
fall_pulse  output  CH  1-cycle pulse on accepted 1->0 (gated by mode[2i+1])
edge_pulse  output  CH  rise_pulse | fall_pulse per channel
edge_flag  output  CH  sticky: set on any enabled edge, cleared by flag_clr
irq  output  1  registered OR of all edge_flag bits

Behaviour:
- Reset uses sys_clk with asynchronous active-low sys_rst_n. On reset, all sync stages and level_out = INIT_LEVEL; debounce counters = 0; rise/fall/edge_pulse = 0; edge_flag = 0; irq = 0.
- Sync: a SYNC_STAGES-deep flop chain per channel. sync_out is the last stage. Nothing downstream uses sig_in directly.
- Debounce counter per channel, width clog2(DEB_CYCLES+1):
  - if sync_out == level_out: cnt <= 0
  - else if cnt == DEB_CYCLES-1: level_out <= sync_out, cnt <= 0, edge accepted this edge
  - else: cnt <= cnt+1
- Latency: sig_in stable before clock edge 0 gives level_out and pulse registered at edge SYNC_STAGES+DEB_CYCLES-1. The pulse is high for exactly one cycle. Defaults give pulse at edge 2.
- Glitch rejection: a change persisting fewer than DEB_CYCLES cycles at sync_out produces no level change and no pulse. The counter restarts on any return to the old level.
- Pulses are registered outputs:
  - rise_pulse[i] = accepted edge & new level 1 & mode[2i]
  - fall_pulse[i] = accepted edge & new level 0 & mode[2i+1]
  - otherwise 0
- Mode handling:
  - level_out tracking runs regardless of mode. Changing mode never generates a pulse; it only gates future accepted edges.
  - Mode is sampled at the accepting edge.
- edge_flag[i]: set when edge_pulse[i] is asserted (same edge as pulse). Cleared when flag_clr[i]=1. Set wins if both occur on the same edge. Holds otherwise.
- irq registered from the next-state edge_flag, so irq rises on the same edge as the flag.
- Channels are fully independent; simultaneous edges on several channels all pulse in the same cycle.
- Reset mid-debounce discards the count. No pulse is produced on or after reset release unless the input differs from INIT_LEVEL, in which case a normal edge is detected after the full latency.

Test Plan:
- Defaults, mode=01 on ch0: sig_in[0] 0->1 before edge 0 -> rise_pulse[0]=1 only in cycle after edge 2, edge_flag[0]=1, irq=1; later 1->0 -> no fall_pulse, level_out[0]=0.
- mode=11 on ch3: toggle sig_in[3] 0->1->0 with 10-cycle spacing -> one rise_pulse, then one fall_pulse; edge_pulse[3] high twice; edge_flag stays 1 until flag_clr[3] pulsed, then 0 and irq=0.
- DEB_CYCLES=4: 3-cycle high glitch -> no pulse, level_out unchanged; 4-cycle high -> rise_pulse at edge SYNC_STAGES+3 after the change.
- flag_clr[1] asserted on the same edge as a new edge_pulse[1] -> edge_flag[1]=1 (set wins).
- mode=00 during an edge, then switch to 01 -> no pulse, no flag, level_out tracks; next rise pulses normally.
- Assert sys_rst_n=0 mid-debounce with sig_in=1, INIT_LEVEL=0 -> all outputs 0 immediately; after release, rise_pulse after the full latency; with sig_in=0 on release, no pulse.
